// File: rtl/time_keeper.sv
// 24-hour BCD time-of-day core with two-key hour/minute set mode.
// The 1 Hz and 10 Hz divider outputs are sampled as data in the XTAL_OSC domain.
module time_keeper (
    input  logic       XTAL_OSC,
    input  logic       rst,
    input  logic       clk_1Hz,
    input  logic       clk_10Hz,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] set_mode,
    output logic       sec_tick
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_e;

    // Bit order: {key_inc, key_mode, clk_10Hz, clk_1Hz}
    logic [3:0] sync1_q, sync2_q;
    logic       p1hz_q, p10hz_q;
    logic       mode_smp_q, inc_smp_q;
    mode_e      state_q, state_d;
    logic [7:0] hour_q, hour_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       sec_tick_q, sec_tick_d;

    logic tick_1s, tick_10, press_mode, press_inc;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return '0;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return v + 8'd1;
    endfunction

    assign tick_1s    = sync2_q[0] & ~p1hz_q;
    assign tick_10    = sync2_q[1] & ~p10hz_q;
    assign press_mode = tick_10 & sync2_q[2] & ~mode_smp_q;
    // A simultaneous mode press takes precedence and swallows the increment.
    assign press_inc  = tick_10 & sync2_q[3] & ~inc_smp_q & ~press_mode;

    always_ff @(posedge XTAL_OSC or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            p1hz_q     <= 1'b0;
            p10hz_q    <= 1'b0;
            mode_smp_q <= 1'b0;
            inc_smp_q  <= 1'b0;
        end else begin
            sync1_q <= {key_inc, key_mode, clk_10Hz, clk_1Hz};
            sync2_q <= sync1_q;
            p1hz_q  <= sync2_q[0];
            p10hz_q <= sync2_q[1];
            if (tick_10) begin
                mode_smp_q <= sync2_q[2];
                inc_smp_q  <= sync2_q[3];
            end
        end
    end

    always_ff @(posedge XTAL_OSC or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    // Tick and key press in one cycle are both resolved under the current mode.
    always_comb begin
        state_d    = state_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        sec_tick_d = 1'b0;
        case (state_q)
            RUN: begin
                if (tick_1s) begin
                    sec_tick_d = 1'b1;
                    sec_d      = bcd_inc(sec_q, 8'h59);
                    if (sec_q == 8'h59) begin
                        min_d = bcd_inc(min_q, 8'h59);
                        if (min_q == 8'h59)
                            hour_d = bcd_inc(hour_q, 8'h23);
                    end
                end
                if (press_mode)
                    state_d = SET_HOUR;
            end
            SET_HOUR: begin
                if (press_mode)
                    state_d = SET_MIN;
                else if (press_inc)
                    hour_d = bcd_inc(hour_q, 8'h23);
            end
            SET_MIN: begin
                if (press_mode) begin
                    state_d = RUN;
                    sec_d   = '0;
                end else if (press_inc) begin
                    min_d = bcd_inc(min_q, 8'h59);
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign hour_bcd = hour_q;
    assign min_bcd  = min_q;
    assign sec_bcd  = sec_q;
    assign set_mode = state_q;
    assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper; expected values are hand-computed constants.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_1Hz = 1'b0;
    logic       clk_10Hz = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic [1:0] set_mode;
    logic       sec_tick;

    int checks = 0;
    int errors = 0;

    time_keeper dut (
        .XTAL_OSC (clk),
        .rst      (rst),
        .clk_1Hz  (clk_1Hz),
        .clk_10Hz (clk_10Hz),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .hour_bcd (hour_bcd),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .set_mode (set_mode),
        .sec_tick (sec_tick)
    );

    always #5 clk = ~clk;

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse10();
        @(negedge clk) clk_10Hz = 1'b1;
        wait_n(4);
        clk_10Hz = 1'b0;
        wait_n(4);
    endtask

    // Press and release with a strobe on each side so key_smp returns to 0.
    task automatic press(input logic m, input logic i);
        @(negedge clk);
        key_mode = m;
        key_inc  = i;
        wait_n(3);
        pulse10();
        key_mode = 1'b0;
        key_inc  = 1'b0;
        wait_n(3);
        pulse10();
    endtask

    task automatic press_n(input logic m, input logic i, input int n);
        for (int k = 0; k < n; k++) press(m, i);
    endtask

    task automatic one_tick(output int pulses);
        pulses = 0;
        @(negedge clk) clk_1Hz = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (sec_tick) pulses++;
        end
        clk_1Hz = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (sec_tick) pulses++;
        end
    endtask

    task automatic ticks(input int n, output int pulses);
        int p;
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            one_tick(p);
            pulses += p;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd, set_mode, sec_tick} !== 27'd0) begin
            errors++;
            $display("FAIL reset_initial got %h:%h:%h mode=%b tick=%b want 00:00:00 mode=00 tick=0",
                     hour_bcd, min_bcd, sec_bcd, set_mode, sec_tick);
        end
        wait_n(2);
        rst = 1'b1;
        wait_n(2);
    endtask

    task automatic test_counting();
        int pulses, p;
        pulses = 0;
        @(negedge clk) clk_1Hz = 1'b1;
        wait_n(2);
        checks++;
        if (sec_bcd !== 8'h00 || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got sec=%h tick=%b want sec=00 tick=0", sec_bcd, sec_tick);
        end
        wait_n(1);
        checks++;
        if (sec_bcd !== 8'h01 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL latency_update got sec=%h tick=%b want sec=01 tick=1", sec_bcd, sec_tick);
        end
        if (sec_tick) pulses++;
        wait_n(1);
        checks++;
        if (sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_width got tick=%b want 0", sec_tick);
        end
        wait_n(4);
        clk_1Hz = 1'b0;
        wait_n(8);
        ticks(59, p);
        pulses += p;
        checks++;
        if (pulses !== 60) begin
            errors++;
            $display("FAIL tick_count got %0d want 60", pulses);
        end
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000100) begin
            errors++;
            $display("FAIL count_60 got %h:%h:%h want 00:01:00", hour_bcd, min_bcd, sec_bcd);
        end
    endtask

    task automatic test_set_hour();
        int pulses, p;
        ticks(7, p);
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000107) begin
            errors++;
            $display("FAIL pre_set got %h:%h:%h want 00:01:07", hour_bcd, min_bcd, sec_bcd);
        end
        press(1'b1, 1'b0);
        checks++;
        if (set_mode !== 2'b01) begin
            errors++;
            $display("FAIL enter_set_hour got %b want 01", set_mode);
        end
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            press(1'b0, 1'b1);
            one_tick(p);
            pulses += p;
        end
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h010107) begin
            errors++;
            $display("FAIL set_hour_25 got %h:%h:%h want 01:01:07", hour_bcd, min_bcd, sec_bcd);
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL set_hour_sec_tick got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_key_rules();
        @(negedge clk) key_inc = 1'b1;
        wait_n(3);
        for (int k = 0; k < 5; k++) pulse10();
        key_inc = 1'b0;
        wait_n(3);
        pulse10();
        checks++;
        if (hour_bcd !== 8'h02) begin
            errors++;
            $display("FAIL held_inc got hour=%h want 02", hour_bcd);
        end
        @(negedge clk) key_inc = 1'b1;
        @(negedge clk) key_inc = 1'b0;
        wait_n(5);
        pulse10();
        checks++;
        if (hour_bcd !== 8'h02) begin
            errors++;
            $display("FAIL glitch_inc got hour=%h want 02", hour_bcd);
        end
        press(1'b1, 1'b1);
        checks++;
        if (set_mode !== 2'b10 || hour_bcd !== 8'h02 || min_bcd !== 8'h01) begin
            errors++;
            $display("FAIL mode_and_inc got mode=%b %h:%h want mode=10 02:01", set_mode, hour_bcd, min_bcd);
        end
    endtask

    task automatic test_set_min();
        press_n(1'b0, 1'b1, 58);
        checks++;
        if (min_bcd !== 8'h59) begin
            errors++;
            $display("FAIL set_min_59 got min=%h want 59", min_bcd);
        end
        press(1'b0, 1'b1);
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h020007) begin
            errors++;
            $display("FAIL set_min_wrap got %h:%h:%h want 02:00:07", hour_bcd, min_bcd, sec_bcd);
        end
        press(1'b1, 1'b0);
        checks++;
        if (set_mode !== 2'b00 || sec_bcd !== 8'h00) begin
            errors++;
            $display("FAIL exit_set got mode=%b sec=%h want mode=00 sec=00", set_mode, sec_bcd);
        end
    endtask

    task automatic test_rollover();
        int p;
        press(1'b1, 1'b0);
        press_n(1'b0, 1'b1, 21);
        press(1'b1, 1'b0);
        press_n(1'b0, 1'b1, 59);
        press(1'b1, 1'b0);
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd, set_mode} !== {24'h235900, 2'b00}) begin
            errors++;
            $display("FAIL preload got %h:%h:%h mode=%b want 23:59:00 mode=00",
                     hour_bcd, min_bcd, sec_bcd, set_mode);
        end
        ticks(59, p);
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h235959) begin
            errors++;
            $display("FAIL pre_roll got %h:%h:%h want 23:59:59", hour_bcd, min_bcd, sec_bcd);
        end
        ticks(1, p);
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000 || p !== 1) begin
            errors++;
            $display("FAIL rollover got %h:%h:%h pulses=%0d want 00:00:00 pulses=1",
                     hour_bcd, min_bcd, sec_bcd, p);
        end
    endtask

    task automatic test_reset_midcount();
        int p;
        press(1'b1, 1'b0);
        press_n(1'b0, 1'b1, 12);
        press(1'b1, 1'b0);
        press_n(1'b0, 1'b1, 34);
        press(1'b1, 1'b0);
        ticks(56, p);
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h123456) begin
            errors++;
            $display("FAIL preload_123456 got %h:%h:%h want 12:34:56", hour_bcd, min_bcd, sec_bcd);
        end
        @(negedge clk) clk_1Hz = 1'b1;
        wait_n(2);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd, set_mode, sec_tick} !== 27'd0) begin
            errors++;
            $display("FAIL reset_async got %h:%h:%h mode=%b tick=%b want 00:00:00 mode=00 tick=0",
                     hour_bcd, min_bcd, sec_bcd, set_mode, sec_tick);
        end
        clk_1Hz = 1'b0;
        wait_n(2);
        rst = 1'b1;
        wait_n(4);
        checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin
            errors++;
            $display("FAIL post_reset got %h:%h:%h want 00:00:00", hour_bcd, min_bcd, sec_bcd);
        end
    endtask

    initial begin
        test_reset();
        test_counting();
        test_set_hour();
        test_key_rules();
        test_set_min();
        test_rollover();
        test_reset_midcount();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
# time_keeper

Time-of-day core of the digital clock. Consumes the divider's 1 Hz and 10 Hz square waves as data in the 100 MHz domain and keeps hours/minutes/seconds in BCD (24-hour). Provides a two-key set mode for hours and minutes. Feeds the display scan stage.

## Interface
Parameters:
- none

Ports:
- XTAL_OSC  in  1  system clock, 100 MHz; the only clock
- rst  in  1  asynchronous active-low reset
- clk_1Hz  in  1  1 Hz square wave from the divider; sampled as data, never used as a clock
- clk_10Hz  in  1  10 Hz square wave from the divider; key sampling strobe source
- key_mode  in  1  mode key, active-high, raw level
- key_inc  in  1  increment key, active-high, raw level
- hour_bcd  out  8  hours, BCD 00..23
- min_bcd  out  8  minutes, BCD 00..59
- sec_bcd  out  8  seconds, BCD 00..59
- set_mode  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN; 11 is never output
- sec_tick  out  1  one-cycle pulse, coincident with each RUN-mode seconds update

## Operation
- Input conditioning: 2-FF synchronizer on each of clk_1Hz, clk_10Hz, key_mode and key_inc. All stages reset to 0.
- tick_1s = rising edge of the synchronized clk_1Hz; tick_10 = rising edge of the synchronized clk_10Hz. Each is one XTAL_OSC cycle wide and uses a registered previous value that resets to 0.
- Key sampling happens only on tick_10, which gives 100 ms debounce. The synchronized key is captured into key_smp.
  - press = synced key 1 AND key_smp 0, evaluated on tick_10.
  - A held key yields exactly one press.
- FSM (set_mode):
  - RUN + mode press -> SET_HOUR
  - SET_HOUR + mode press -> SET_MIN
  - SET_MIN + mode press -> RUN; sec_bcd is cleared to 00 on this transition
- RUN:
  - On tick_1s: sec +1.
  - sec 59 -> 00 with carry to min; min 59 -> 00 with carry to hour; hour 23 -> 00.
  - 23:59:59 -> 00:00:00 in a single update.
  - inc presses are ignored.
- SET_HOUR: inc press -> hour +1, 23 -> 00. No effect on min or sec. tick_1s is ignored, so seconds are frozen.
- SET_MIN: inc press -> min +1, 59 -> 00. No carry into hour. tick_1s is ignored.
- Mode and inc press on the same tick_10: mode wins and inc is discarded.
- tick_1s and a key press in the same cycle are handled under the current (pre-transition) mode. Example: a tick in RUN counts in the same cycle that mode moves to SET_HOUR.
- Arithmetic is per-digit BCD. Low nibble 9 -> 0 with carry into the high nibble. Hour wrap is detected on the full value 8'h23. A non-BCD value is unreachable.

## Timing
- Reset (rst low, async): hour_bcd = min_bcd = sec_bcd = 8'h00, set_mode = 2'b00, sec_tick = 0, all synchronizer, previous-value and key_smp flops = 0. Effect is immediate and mid-operation, from any state.
- Seconds latency: clk_1Hz first sampled high at edge k.
  - sync stage 2 is high after edge k+1.
  - tick_1s is high during the k+1..k+2 cycle.
  - sec_bcd/min_bcd/hour_bcd update at edge k+2.
  - sec_tick is high from edge k+2 to k+3.
- A clk_1Hz already high at reset release produces one tick_1s 2 cycles after release. This is accepted; the divider resets its output low.
- Key latency: the press registers on the first tick_10 after the synchronized key is high. That is 2 cycles plus up to 100 ms.
- Key pulses shorter than one 10 Hz period that fall between sample points are missed. This is by design.
- All outputs are registered.

## Test plan
- Reset: assert rst mid-count at 12:34:56 -> all time outputs 8'h00, set_mode 00, sec_tick 0, with no clock edge required.
- Counting (bench toggles clk_1Hz every 8 cycles): 60 rising edges from 00:00:00 -> 00:01:00. Exactly 60 sec_tick pulses. Each update lands 2 cycles after the sampling edge.
- Rollover: preload via set mode to 23:59, exit (sec 00), apply 59 ticks then 1 more -> 23:59:59 then 00:00:00.
- SET_HOUR:
  - One mode press -> set_mode 01.
  - 25 inc presses from hour 00 -> hour 8'h01.
  - clk_1Hz edges during this time leave sec_bcd unchanged.
  - sec_tick stays 0.
- SET_MIN: min at 59, one inc press -> min 00, hour unchanged. Mode press -> set_mode 00, sec_bcd 00.
- Key rules:
  - key_mode and key_inc rise together -> only the mode advances.
  - key_inc held high across 5 tick_10 strobes -> exactly one increment.
  - A 1-cycle key glitch between strobes -> no effect.
